// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity
// bit, one stop bit, then a single-cycle DONE state. Every output is taken
// straight from a flop, and each one is loaded with the value that belongs
// to the state being entered, so tx changes on the same edge as the state.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       tx,
  output logic       txDone,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic        PAR_EN_L  = (PARITY_EN != 0);
  localparam logic        PAR_ODD_L = (PARITY_ODD != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par;

  logic        w_baud_end;
  logic        w_busy_state;
  logic        w_accept;
  logic        w_abort;
  logic [15:0] w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_par_nxt;
  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;

  assign w_baud_end   = (r_baud == BAUD_LAST);
  assign w_busy_state = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_accept     = (r_state == S_IDLE) && tx_en && txStart;
  // Dropping the enable wins over any bit boundary in the same cycle.
  assign w_abort      = w_busy_state && !tx_en;

  // State register plus baud/bit counters, shift register and latched parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Next-state decision: each bit state advances when its baud period ends.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_baud_end && (r_bit == 3'd7)) begin
          w_state_nxt = PAR_EN_L ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_baud_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_baud_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values: counters clear on every state change or bit end.
  always_comb begin
    w_baud_nxt  = r_baud + 16'd1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    if ((w_state_nxt != r_state) || w_baud_end || !w_busy_state) begin
      w_baud_nxt = 16'd0;
    end
    if (w_accept) begin
      w_bit_nxt   = 3'd0;
      w_shift_nxt = txData;
      w_par_nxt   = (^txData) ^ PAR_ODD_L;
    end else if (w_abort) begin
      w_bit_nxt = 3'd0;
    end else if ((r_state == S_DATA) && w_baud_end) begin
      w_bit_nxt   = r_bit + 3'd1;
      w_shift_nxt = {1'b0, r_shift[7:1]};
    end
  end

  // Output decode for the state being entered, so the flops below line up
  // with the state register.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = w_abort;
    case (w_state_nxt)
      S_START: begin
        w_tx_nxt   = 1'b0;
        w_busy_nxt = 1'b1;
      end
      S_DATA: begin
        w_tx_nxt   = w_shift_nxt[0];
        w_busy_nxt = 1'b1;
      end
      S_PARITY: begin
        w_tx_nxt   = r_par;
        w_busy_nxt = 1'b1;
      end
      S_STOP: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  // Output flops keep tx, txDone, busy and err glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx     <= 1'b1;
      txDone <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      tx     <= w_tx_nxt;
      txDone <= w_done_nxt;
      busy   <= w_busy_nxt;
      err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three instances (even parity, no parity, odd
// parity) at 4 clocks per bit, checked against a bit-list frame model.
module tb_uart_tx_engine;

  localparam int CLKS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] tx_en;
  logic [2:0] txStart;
  logic [7:0] txData [3];
  logic [2:0] tx;
  logic [2:0] txDone;
  logic [2:0] busy;
  logic [2:0] err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] obs_tx;
  logic [63:0] obs_busy;
  logic [63:0] obs_done;
  logic [63:0] obs_err;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[0]), .txStart(txStart[0]),
    .txData(txData[0]), .tx(tx[0]), .txDone(txDone[0]), .busy(busy[0]),
    .err(err[0]));

  uart_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[1]), .txStart(txStart[1]),
    .txData(txData[1]), .tx(tx[1]), .txDone(txDone[1]), .busy(busy[1]),
    .err(err[1]));

  uart_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[2]), .txStart(txStart[2]),
    .txData(txData[2]), .tx(tx[2]), .txDone(txDone[2]), .busy(busy[2]),
    .err(err[2]));

  function automatic bit pe(input int k);
    return (k != 1);
  endfunction

  function automatic bit po(input int k);
    return (k == 2);
  endfunction

  function automatic int frame_len(input int k);
    return (pe(k) ? 11 : 10) * CLKS;
  endfunction

  // Frame as a list of serial bits, each stretched to CLKS samples; the
  // bits beyond the frame are the idle-high gap.
  function automatic logic [63:0] exp_tx(input int k, input logic [7:0] d);
    logic [63:0] v;
    int n;
    int nb;
    logic b;
    v  = '1;
    n  = 0;
    nb = pe(k) ? 11 : 10;
    for (int p = 0; p < nb; p++) begin
      if (p == 0)                b = 1'b0;
      else if (p <= 8)           b = d[p-1];
      else if (p == 9 && pe(k))  b = (^d) ^ po(k);
      else                       b = 1'b1;
      for (int c = 0; c < CLKS; c++) begin
        v[n] = b;
        n++;
      end
    end
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: requests a frame, records L+2 samples
  // (frame, DONE, IDLE) and compares them with the model. txData is
  // scrambled while busy and set to nxt during DONE.
  task automatic run_frame(input int k, input logic [7:0] d, input bit hold,
                           input logic [7:0] nxt);
    int L;
    logic [63:0] mask;
    L    = frame_len(k);
    mask = (64'd1 << (L + 2)) - 64'd1;
    tx_en[k]   = 1'b1;
    txStart[k] = 1'b1;
    txData[k]  = d;
    obs_tx   = '0;
    obs_busy = '0;
    obs_done = '0;
    obs_err  = '0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      obs_tx[i]   = tx[k];
      obs_busy[i] = busy[k];
      obs_done[i] = txDone[k];
      obs_err[i]  = err[k];
      if (i == 0 && !hold) txStart[k] = 1'b0;
      if (i < L) txData[k] = 8'($urandom);
      else       txData[k] = nxt;
    end
    check_val($sformatf("tx_wave_u%0d_%h", k, d), obs_tx, exp_tx(k, d) & mask);
    check_val($sformatf("busy_u%0d_%h", k, d), obs_busy, (64'd1 << L) - 64'd1);
    check_val($sformatf("done_u%0d_%h", k, d), obs_done, 64'd1 << L);
    check_val($sformatf("err_u%0d_%h", k, d), obs_err, 64'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] nxt;
    logic [63:0] acc;
    int k;
    bit chain;
    bit hold;

    rst_n   = 1'b0;
    tx_en   = 3'b000;
    txStart = 3'b000;
    for (int i = 0; i < 3; i++) txData[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_tx", 64'(tx), 64'(3'b111));
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(txDone), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);

    // Acceptance on the very first edge after reset release.
    rst_n = 1'b1;
    tx_en = 3'b111;
    run_frame(0, 8'hA5, 1'b0, 8'h00);
    check_val("a5_literal", 64'(obs_tx[43:0]), 64'(44'hF0F0F00F0F0));

    // No acceptance while the enable is low.
    tx_en[0]   = 1'b0;
    txStart[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc[i] = busy[0] | ~tx[0];
    end
    check_val("no_accept_en_low", acc, 64'd0);
    txStart[0] = 1'b0;
    tx_en[0]   = 1'b1;
    @(negedge clk);

    // No-parity, all-zero byte.
    run_frame(1, 8'h00, 1'b0, 8'h00);
    check_val("zero_low_cycles", 64'(40 - $countones(obs_tx[39:0])), 64'd36);
    check_val("zero_busy_cycles", 64'($countones(obs_busy)), 64'd40);

    // Back-to-back frames with txStart held and new byte loaded in DONE.
    run_frame(0, 8'h11, 1'b1, 8'h22);
    run_frame(0, 8'h22, 1'b0, 8'h00);

    // Abort during data bit 3.
    d = 8'($urandom);
    txStart[0] = 1'b1;
    txData[0]  = d;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) txStart[0] = 1'b0;
    end
    check_val("abort_pre_bit3", 64'(tx[0]), 64'(d[3]));
    tx_en[0] = 1'b0;
    @(negedge clk);
    check_val("abort_edge", 64'({tx[0], busy[0], err[0], txDone[0]}), 64'(4'b1010));
    @(negedge clk);
    check_val("abort_after", 64'({tx[0], busy[0], err[0], txDone[0]}), 64'(4'b1000));
    tx_en[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc[i] = txDone[0] | err[0] | busy[0];
    end
    check_val("abort_quiet", acc, 64'd0);

    // Asynchronous reset in the middle of the parity bit.
    d = 8'($urandom);
    txStart[0] = 1'b1;
    txData[0]  = d;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (i == 0) txStart[0] = 1'b0;
    end
    check_val("par_before_rst", 64'(tx[0]), 64'(^d));
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst", 64'({tx[0], busy[0], err[0], txDone[0]}), 64'(4'b1000));
    @(negedge clk);
    check_val("rst_held", 64'({tx[0], busy[0], err[0], txDone[0]}), 64'(4'b1000));
    rst_n = 1'b1;
    run_frame(0, 8'($urandom), 1'b0, 8'h00);

    // Odd parity corner bytes.
    run_frame(2, 8'hFF, 1'b0, 8'h00);
    check_val("odd_par_ff", 64'(obs_tx[37]), 64'd1);
    run_frame(2, 8'h01, 1'b0, 8'h00);
    check_val("odd_par_01", 64'(obs_tx[37]), 64'd0);

    // Randomised frames, random gaps, random back-to-back chains.
    chain = 1'b0;
    k = 0;
    d = 8'h00;
    for (int n = 0; n < 30; n++) begin
      if (!chain) begin
        k = $urandom_range(0, 2);
        d = 8'($urandom);
      end
      hold = (n < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      nxt  = 8'($urandom);
      run_frame(k, d, hold, nxt);
      if (hold) begin
        chain = 1'b1;
        d = nxt;
      end else begin
        chain = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 1, 1 = parity bit inserted after data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tx_en  input  1  transmitter enable from upstream APB interface.
REQ-007 txStart  input  1  level request to send txData.
REQ-008 txData  input  8  byte to send, sampled on acceptance only.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 txDone  output  1  one-cycle pulse, frame completed.
REQ-011 busy  output  1  frame in progress.
REQ-012 err  output  1  one-cycle pulse, frame aborted.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE; all registered.
REQ-014 Acceptance SHALL occur on an edge where state=IDLE, tx_en=1, txStart=1: txData latched into shift register, bit counter=0, baud counter=0, next state START.
REQ-015 txStart SHALL be level-sensitive; txStart held high across frames SHALL start a new frame each time IDLE is re-entered.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1; each bit state is held exactly CLKS_PER_BIT cycles; counter clears on every state change.
REQ-017 tx SHALL be 0 in START, shift-register LSB in DATA (LSB first), parity bit in PARITY, 1 in STOP, DONE, IDLE.
REQ-018 DATA SHALL run 8 bits; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
REQ-019 Parity bit SHALL equal XOR of the 8 latched bits, inverted when PARITY_ODD=1.
REQ-020 STOP SHALL be one bit long, then DONE.
REQ-021 DONE SHALL last exactly 1 cycle with txDone=1, then IDLE; no acceptance in DONE.
REQ-022 Minimum gap between frames: 2 cycles (DONE + IDLE acceptance edge) with tx=1.
REQ-023 busy SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE and DONE.
REQ-024 tx_en low in any busy state SHALL abort: next state IDLE, tx=1, err=1 for one cycle, txDone not asserted.
REQ-025 txStart or txData changes while busy SHALL have no effect on the frame in progress.
REQ-026 Latency: tx falls on the first edge after acceptance; txDone asserts (1+8+PARITY_EN+1)*CLKS_PER_BIT cycles after tx falls.
REQ-027 tx, txDone, busy, err SHALL be driven directly from flops (glitch-free).

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, tx=1, txDone=0, busy=0, err=0, all counters and shift register=0.
REQ-029 Reset asserted mid-frame SHALL truncate the frame immediately with tx=1; no txDone, no err.
REQ-030 After rst_n deasserts, the first acceptance is possible on the first clk edge with IDLE conditions met.

Verification (CLKS_PER_BIT=4)
REQ-031 PARITY_EN=1, even; txData=0xA5 accepted -> tx = 0 then 1,0,1,0,0,1,0,1 then parity 0 then 1, each 4 cycles; txDone pulse 44 cycles after tx falls.
REQ-032 PARITY_EN=0; txData=0x00 -> 36 cycles low-data frame (start + 8 zeros = 36 cycles low), 4 cycles stop high, txDone once, busy high 40 cycles.
REQ-033 txStart held high, txData 0x11 then 0x22 updated during DONE -> two back-to-back frames, 2-cycle high gap, two txDone pulses, second frame carries 0x22.
REQ-034 tx_en dropped during DATA bit 3 -> tx=1 next cycle, err pulse 1 cycle, busy=0, no txDone.
REQ-035 rst_n pulsed low mid-PARITY -> tx=1, busy=0 immediately without waiting for clk; next accepted frame is bit-exact.
REQ-036 PARITY_ODD=1, txData=0xFF -> parity bit 1; txData=0x01 -> parity bit 0.
